// File: rtl/vga_anim_pkg.sv
// Shared types and default 640x480 timing for the VGA sprite animator.
package vga_anim_pkg;

   typedef enum logic [1:0] {
      DIR_RIGHT = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_UP    = 2'd3
   } dir_t;

   typedef enum logic {
      ST_PAUSED = 1'b0,
      ST_RUN    = 1'b1
   } state_t;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   // Total period of one axis: visible span plus both porches and the sync pulse.
   function automatic int total_span(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical counters and the raw (unregistered) timing decodes
// derived from them: active video flag, active-low syncs and frame_start.
module vga_timing_gen
   import vga_anim_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int H_CNT_W  = $clog2(total_span(H_ACTIVE, H_FP, H_SYNC, H_BP)),
   parameter int V_CNT_W  = $clog2(total_span(V_ACTIVE, V_FP, V_SYNC, V_BP))
)
(
   input  logic               clk,
   input  logic               reset,
   output logic [H_CNT_W-1:0] h_count,
   output logic [V_CNT_W-1:0] v_count,
   output logic               active,
   output logic               hs_n,
   output logic               vs_n,
   output logic               frame_start
);

   localparam int H_TOTAL = total_span(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = total_span(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam logic [H_CNT_W-1:0] H_LAST     = H_CNT_W'(H_TOTAL - 1);
   localparam logic [H_CNT_W-1:0] H_ACT_END  = H_CNT_W'(H_ACTIVE);
   localparam logic [H_CNT_W-1:0] H_SYNC_BEG = H_CNT_W'(H_ACTIVE + H_FP);
   localparam logic [H_CNT_W-1:0] H_SYNC_END = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [V_CNT_W-1:0] V_LAST     = V_CNT_W'(V_TOTAL - 1);
   localparam logic [V_CNT_W-1:0] V_ACT_END  = V_CNT_W'(V_ACTIVE);
   localparam logic [V_CNT_W-1:0] V_SYNC_BEG = V_CNT_W'(V_ACTIVE + V_FP);
   localparam logic [V_CNT_W-1:0] V_SYNC_END = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   // Pixel counter runs every clk; the line counter steps when the pixel counter wraps.
   always_ff @(posedge clk) begin
      if (reset) begin
         h_count <= '0;
         v_count <= '0;
      end else if (h_count == H_LAST) begin
         h_count <= '0;
         if (v_count == V_LAST) begin
            v_count <= '0;
         end else begin
            v_count <= v_count + V_CNT_W'(1);
         end
      end else begin
         h_count <= h_count + H_CNT_W'(1);
      end
   end

   // Decode visible region, sync windows and the start-of-vertical-blank pulse.
   always_comb begin
      active      = (h_count < H_ACT_END) && (v_count < V_ACT_END);
      hs_n        = !((h_count >= H_SYNC_BEG) && (h_count < H_SYNC_END));
      vs_n        = !((v_count >= V_SYNC_BEG) && (v_count < V_SYNC_END));
      frame_start = (h_count == '0) && (v_count == V_ACT_END);
   end

endmodule

// File: rtl/vga_sprite_animator.sv
// VGA timing plus a square sprite that moves once per FRAME_DIV frames,
// bouncing or wrapping at the screen edges. All VGA pins are registered.
module vga_sprite_animator
   import vga_anim_pkg::*;
#(
   parameter int H_ACTIVE    = DEF_H_ACTIVE,
   parameter int H_FP        = DEF_H_FP,
   parameter int H_SYNC      = DEF_H_SYNC,
   parameter int H_BP        = DEF_H_BP,
   parameter int V_ACTIVE    = DEF_V_ACTIVE,
   parameter int V_FP        = DEF_V_FP,
   parameter int V_SYNC      = DEF_V_SYNC,
   parameter int V_BP        = DEF_V_BP,
   parameter int SPRITE_SIZE = 4,
   parameter int SPEED       = 2,
   parameter int FRAME_DIV   = 1,
   parameter int COLOR_W     = 3
)
(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic                        bounce_en,
   input  logic [1:0]                  dir_in,
   input  logic                        dir_load,
   input  logic [3*COLOR_W-1:0]        sprite_rgb,
   output logic [COLOR_W-1:0]          VGA_R,
   output logic [COLOR_W-1:0]          VGA_G,
   output logic [COLOR_W-1:0]          VGA_B,
   output logic                        VGA_HS,
   output logic                        VGA_VS,
   output logic                        VGA_BLANK_N,
   output logic                        VGA_SYNC_N,
   output logic                        frame_start,
   output logic [$clog2(H_ACTIVE)-1:0] sprite_x,
   output logic [$clog2(V_ACTIVE)-1:0] sprite_y
);

   localparam int H_CNT_W = $clog2(total_span(H_ACTIVE, H_FP, H_SYNC, H_BP));
   localparam int V_CNT_W = $clog2(total_span(V_ACTIVE, V_FP, V_SYNC, V_BP));
   localparam int X_W     = $clog2(H_ACTIVE);
   localparam int Y_W     = $clog2(V_ACTIVE);
   localparam int HE_W    = H_CNT_W + 1;
   localparam int VE_W    = V_CNT_W + 1;
   localparam int DIV_W   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

   localparam logic [X_W-1:0]   X_RESET  = X_W'((H_ACTIVE - SPRITE_SIZE) / 2);
   localparam logic [Y_W-1:0]   Y_RESET  = Y_W'((V_ACTIVE - SPRITE_SIZE) / 2);
   localparam logic [X_W-1:0]   X_MAX    = X_W'(H_ACTIVE - SPRITE_SIZE);
   localparam logic [Y_W-1:0]   Y_MAX    = Y_W'(V_ACTIVE - SPRITE_SIZE);
   localparam logic [X_W:0]     X_MAX_E  = (X_W+1)'(H_ACTIVE - SPRITE_SIZE);
   localparam logic [Y_W:0]     Y_MAX_E  = (Y_W+1)'(V_ACTIVE - SPRITE_SIZE);
   localparam logic [X_W:0]     SPEED_XE = (X_W+1)'(SPEED);
   localparam logic [Y_W:0]     SPEED_YE = (Y_W+1)'(SPEED);
   localparam logic [X_W-1:0]   SPEED_X  = X_W'(SPEED);
   localparam logic [Y_W-1:0]   SPEED_Y  = Y_W'(SPEED);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

   logic [H_CNT_W-1:0] h_count;
   logic [V_CNT_W-1:0] v_count;
   logic               active;
   logic               hs_n;
   logic               vs_n;
   logic               fs_raw;

   state_t             state_q;
   state_t             state_d;
   logic [DIV_W-1:0]   div_q;
   dir_t               dir_q;
   dir_t               pend_dir;
   logic               pend_valid;
   logic               do_update;
   dir_t               eff_dir;
   dir_t               dir_d;
   logic [X_W-1:0]     x_d;
   logic [Y_W-1:0]     y_d;
   logic [X_W:0]       nx_sum;
   logic [Y_W:0]       ny_sum;
   logic               in_sprite;
   logic [HE_W-1:0]    h_e;
   logic [HE_W-1:0]    x_lo;
   logic [VE_W-1:0]    v_e;
   logic [VE_W-1:0]    y_lo;

   vga_timing_gen #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP),
      .H_CNT_W  (H_CNT_W),
      .V_CNT_W  (V_CNT_W)
   ) u_timing (
      .clk         (clk),
      .reset       (reset),
      .h_count     (h_count),
      .v_count     (v_count),
      .active      (active),
      .hs_n        (hs_n),
      .vs_n        (vs_n),
      .frame_start (fs_raw)
   );

   assign frame_start = fs_raw;
   assign VGA_SYNC_N  = 1'b0;

   // The sprite occupies [x, x+SIZE) by [y, y+SIZE); widened so x+SIZE cannot overflow.
   always_comb begin
      h_e       = HE_W'(h_count);
      x_lo      = HE_W'(sprite_x);
      v_e       = VE_W'(v_count);
      y_lo      = VE_W'(sprite_y);
      in_sprite = (h_e >= x_lo) && (h_e < x_lo + HE_W'(SPRITE_SIZE)) &&
                  (v_e >= y_lo) && (v_e < y_lo + VE_W'(SPRITE_SIZE));
   end

   // Register syncs, blank and colour together so they leave the chip aligned.
   always_ff @(posedge clk) begin
      if (reset) begin
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         VGA_BLANK_N <= 1'b0;
         VGA_R       <= '0;
         VGA_G       <= '0;
         VGA_B       <= '0;
      end else begin
         VGA_HS      <= hs_n;
         VGA_VS      <= vs_n;
         VGA_BLANK_N <= active;
         if (active && in_sprite) begin
            {VGA_R, VGA_G, VGA_B} <= sprite_rgb;
         end else begin
            VGA_R <= '0;
            VGA_G <= '0;
            VGA_B <= '0;
         end
      end
   end

   // Run/pause follows enable; movement is only allowed at the start of vertical blank.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_PAUSED: if (enable)  state_d = ST_RUN;
         ST_RUN:    if (!enable) state_d = ST_PAUSED;
         default:   state_d = ST_PAUSED;
      endcase
      do_update = (state_q == ST_RUN) && fs_raw && (div_q == DIV_LAST);
   end

   // Next position: pending direction first, then one step with bounce or wrap at the edges.
   always_comb begin
      eff_dir = pend_valid ? pend_dir : dir_q;
      dir_d   = eff_dir;
      x_d     = sprite_x;
      y_d     = sprite_y;
      nx_sum  = {1'b0, sprite_x} + SPEED_XE;
      ny_sum  = {1'b0, sprite_y} + SPEED_YE;
      case (eff_dir)
         DIR_RIGHT: begin
            if (nx_sum > X_MAX_E) begin
               x_d = bounce_en ? X_MAX : '0;
               if (bounce_en) dir_d = DIR_LEFT;
            end else begin
               x_d = nx_sum[X_W-1:0];
            end
         end
         DIR_LEFT: begin
            if ({1'b0, sprite_x} < SPEED_XE) begin
               x_d = bounce_en ? '0 : X_MAX;
               if (bounce_en) dir_d = DIR_RIGHT;
            end else begin
               x_d = sprite_x - SPEED_X;
            end
         end
         DIR_DOWN: begin
            if (ny_sum > Y_MAX_E) begin
               y_d = bounce_en ? Y_MAX : '0;
               if (bounce_en) dir_d = DIR_UP;
            end else begin
               y_d = ny_sum[Y_W-1:0];
            end
         end
         DIR_UP: begin
            if ({1'b0, sprite_y} < SPEED_YE) begin
               y_d = bounce_en ? '0 : Y_MAX;
               if (bounce_en) dir_d = DIR_DOWN;
            end else begin
               y_d = sprite_y - SPEED_Y;
            end
         end
         default: dir_d = eff_dir;
      endcase
   end

   // State, frame divider, position and direction registers; a new strobe beats the clear on update.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_PAUSED;
         div_q      <= '0;
         sprite_x   <= X_RESET;
         sprite_y   <= Y_RESET;
         dir_q      <= DIR_RIGHT;
         pend_dir   <= DIR_RIGHT;
         pend_valid <= 1'b0;
      end else begin
         state_q <= state_d;
         if ((state_q == ST_RUN) && fs_raw) begin
            div_q <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
         end
         if (do_update) begin
            sprite_x <= x_d;
            sprite_y <= y_d;
            dir_q    <= dir_d;
         end
         if (dir_load) begin
            pend_dir   <= dir_t'(dir_in);
            pend_valid <= 1'b1;
         end else if (do_update) begin
            pend_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_vga_sprite_animator.sv
// Directed bench for vga_sprite_animator on a shrunken 16x12 screen so that
// many frames fit in a short run.
module tb_vga_sprite_animator;

   localparam int TH_A  = 16;
   localparam int TH_FP = 2;
   localparam int TH_S  = 3;
   localparam int TH_BP = 3;
   localparam int TV_A  = 12;
   localparam int TV_FP = 1;
   localparam int TV_S  = 2;
   localparam int TV_BP = 2;
   localparam int H_TOT = TH_A + TH_FP + TH_S + TH_BP;
   localparam int V_TOT = TV_A + TV_FP + TV_S + TV_BP;
   localparam int FRAME = H_TOT * V_TOT;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       bounce_en;
   logic [1:0] dir_in;
   logic       dir_load;
   logic [8:0] sprite_rgb;
   logic [2:0] VGA_R;
   logic [2:0] VGA_G;
   logic [2:0] VGA_B;
   logic       VGA_HS;
   logic       VGA_VS;
   logic       VGA_BLANK_N;
   logic       VGA_SYNC_N;
   logic       frame_start;
   logic [3:0] sprite_x;
   logic [3:0] sprite_y;

   int checks;
   int failures;
   int mh;
   int mv;
   int step_no;
   int vid_err;
   int hs_low;
   int vs_low;
   int blank_high;
   int fs_count;
   int red_pix;
   int first_hs_low;
   int first_vs_low;
   logic chk_video;

   vga_sprite_animator #(
      .H_ACTIVE    (TH_A),
      .H_FP        (TH_FP),
      .H_SYNC      (TH_S),
      .H_BP        (TH_BP),
      .V_ACTIVE    (TV_A),
      .V_FP        (TV_FP),
      .V_SYNC      (TV_S),
      .V_BP        (TV_BP),
      .SPRITE_SIZE (4),
      .SPEED       (2),
      .FRAME_DIV   (1),
      .COLOR_W     (3)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .bounce_en   (bounce_en),
      .dir_in      (dir_in),
      .dir_load    (dir_load),
      .sprite_rgb  (sprite_rgb),
      .VGA_R       (VGA_R),
      .VGA_G       (VGA_G),
      .VGA_B       (VGA_B),
      .VGA_HS      (VGA_HS),
      .VGA_VS      (VGA_VS),
      .VGA_BLANK_N (VGA_BLANK_N),
      .VGA_SYNC_N  (VGA_SYNC_N),
      .frame_start (frame_start),
      .sprite_x    (sprite_x),
      .sprite_y    (sprite_y)
   );

   // Free-running pixel clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic bnc);
      enable    = en;
      bounce_en = bnc;
   endtask

   task automatic resetTallies();
      step_no      = 0;
      vid_err      = 0;
      hs_low       = 0;
      vs_low       = 0;
      blank_high   = 0;
      fs_count     = 0;
      red_pix      = 0;
      first_hs_low = -1;
      first_vs_low = -1;
   endtask

   task automatic stepCycle();
      int         ph;
      int         pv;
      logic       rs;
      logic       e_act;
      logic       e_hs;
      logic       e_vs;
      logic       e_spr;
      logic [8:0] rgb_s;
      logic [11:0] exp_v;
      logic [11:0] got_v;
      ph    = mh;
      pv    = mv;
      rs    = reset;
      rgb_s = sprite_rgb;
      @(posedge clk);
      if (rs) begin
         mh = 0;
         mv = 0;
      end else if (mh == H_TOT - 1) begin
         mh = 0;
         mv = (mv == V_TOT - 1) ? 0 : mv + 1;
      end else begin
         mh = mh + 1;
      end
      @(negedge clk);
      step_no++;
      e_act = !rs && (ph < TH_A) && (pv < TV_A);
      e_hs  = rs || !((ph >= TH_A + TH_FP) && (ph < TH_A + TH_FP + TH_S));
      e_vs  = rs || !((pv >= TV_A + TV_FP) && (pv < TV_A + TV_FP + TV_S));
      e_spr = e_act && (ph >= 6) && (ph < 10) && (pv >= 4) && (pv < 8);
      exp_v = {e_hs, e_vs, e_act, (e_spr ? rgb_s : 9'd0)};
      got_v = {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B};
      if (chk_video) begin
         if (got_v !== exp_v) vid_err++;
         if (frame_start !== ((mh == 0) && (mv == TV_A))) vid_err++;
         if (VGA_SYNC_N !== 1'b0) vid_err++;
      end
      if (VGA_HS === 1'b0) begin
         hs_low++;
         if (first_hs_low < 0) first_hs_low = step_no;
      end
      if (VGA_VS === 1'b0) begin
         vs_low++;
         if (first_vs_low < 0) first_vs_low = step_no;
      end
      if (VGA_BLANK_N === 1'b1) blank_high++;
      if (frame_start === 1'b1) fs_count++;
      if (VGA_R === 3'd7) red_pix++;
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) stepCycle();
   endtask

   task automatic waitFrameStart();
      int n;
      n = 0;
      do begin
         stepCycle();
         n++;
      end while ((frame_start !== 1'b1) && (n < 2 * FRAME));
      checkOutput("frame_start_seen", frame_start, 1);
   endtask

   task automatic nextUpdate();
      waitFrameStart();
      stepCycle();
   endtask

   task automatic loadDir(input logic [1:0] d);
      dir_in   = d;
      dir_load = 1'b1;
      stepCycle();
      dir_load = 1'b0;
   endtask

   // Directed sequence: timing, static sprite, motion, edges, direction, pause, mid-frame reset.
   initial begin
      int n;
      checks     = 0;
      failures   = 0;
      mh         = 0;
      mv         = 0;
      chk_video  = 1'b0;
      reset      = 1'b1;
      dir_in     = 2'd0;
      dir_load   = 1'b0;
      sprite_rgb = 9'h1C0;
      applyStimulus(1'b0, 1'b1);
      resetTallies();
      runCycles(2);

      checkOutput("rst_blank_n", VGA_BLANK_N, 0);
      checkOutput("rst_hs", VGA_HS, 1);
      checkOutput("rst_vs", VGA_VS, 1);
      checkOutput("rst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
      checkOutput("rst_frame_start", frame_start, 0);
      checkOutput("rst_x", sprite_x, 6);
      checkOutput("rst_y", sprite_y, 4);
      checkOutput("sync_n", VGA_SYNC_N, 0);

      reset = 1'b0;
      resetTallies();
      chk_video = 1'b1;
      runCycles(2 * FRAME);
      chk_video = 1'b0;
      checkOutput("video_pattern_errs", vid_err, 0);
      checkOutput("hs_low_clks", hs_low, 2 * TV_TOTAL_HS());
      checkOutput("vs_low_clks", vs_low, 2 * TV_S * H_TOT);
      checkOutput("blank_high_clks", blank_high, 2 * TH_A * TV_A);
      checkOutput("frame_start_count", fs_count, 2);
      checkOutput("first_hs_low_step", first_hs_low, TH_A + TH_FP + 1);
      checkOutput("first_vs_low_step", first_vs_low, (TV_A + TV_FP) * H_TOT + 1);
      checkOutput("red_pixels", red_pix, 2 * 16);
      checkOutput("frozen_x", sprite_x, 6);

      applyStimulus(1'b1, 1'b1);
      nextUpdate();
      checkOutput("right_x1", sprite_x, 8);
      checkOutput("right_y1", sprite_y, 4);
      nextUpdate();
      checkOutput("right_x2", sprite_x, 10);
      nextUpdate();
      checkOutput("right_x3", sprite_x, 12);
      nextUpdate();
      checkOutput("bounce_r_x", sprite_x, 12);
      nextUpdate();
      checkOutput("bounce_after_x", sprite_x, 10);

      applyStimulus(1'b1, 1'b0);
      runCycles(50);
      loadDir(2'd0);
      nextUpdate();
      checkOutput("wrap_pre_x", sprite_x, 12);
      nextUpdate();
      checkOutput("wrap_r_x", sprite_x, 0);

      runCycles(50);
      loadDir(2'd3);
      nextUpdate();
      checkOutput("up_y1", sprite_y, 2);
      checkOutput("up_x_hold", sprite_x, 0);
      nextUpdate();
      checkOutput("up_y2", sprite_y, 0);
      nextUpdate();
      checkOutput("wrap_up_y", sprite_y, 8);

      waitFrameStart();
      dir_in   = 2'd1;
      dir_load = 1'b1;
      stepCycle();
      dir_load = 1'b0;
      checkOutput("load_on_fs_y", sprite_y, 6);
      nextUpdate();
      checkOutput("load_applied_y", sprite_y, 8);

      applyStimulus(1'b1, 1'b1);
      nextUpdate();
      checkOutput("bounce_d_y", sprite_y, 8);
      nextUpdate();
      checkOutput("bounce_d_after_y", sprite_y, 6);

      applyStimulus(1'b0, 1'b1);
      waitFrameStart();
      waitFrameStart();
      stepCycle();
      checkOutput("pause_y", sprite_y, 6);
      checkOutput("pause_x", sprite_x, 0);
      applyStimulus(1'b1, 1'b1);
      nextUpdate();
      checkOutput("resume_y", sprite_y, 4);

      runCycles(50);
      loadDir(2'd0);
      runCycles(3);
      loadDir(2'd2);
      nextUpdate();
      checkOutput("last_wins_x1", sprite_x, 0);
      checkOutput("last_wins_y", sprite_y, 4);
      nextUpdate();
      checkOutput("last_wins_x2", sprite_x, 2);

      applyStimulus(1'b0, 1'b1);
      n = 0;
      while (!((mh == 10) && (mv == 5)) && (n < 2 * FRAME)) begin
         stepCycle();
         n++;
      end
      checkOutput("reach_mid_frame", ((mh == 10) && (mv == 5)), 1);
      reset = 1'b1;
      stepCycle();
      reset = 1'b0;
      checkOutput("mid_rst_blank_n", VGA_BLANK_N, 0);
      checkOutput("mid_rst_hs", VGA_HS, 1);
      checkOutput("mid_rst_x", sprite_x, 6);
      checkOutput("mid_rst_y", sprite_y, 4);
      checkOutput("mid_rst_frame_start", frame_start, 0);
      resetTallies();
      chk_video = 1'b1;
      runCycles(FRAME);
      chk_video = 1'b0;
      checkOutput("post_rst_video_errs", vid_err, 0);
      checkOutput("post_rst_blank_high", blank_high, TH_A * TV_A);
      checkOutput("post_rst_red_pixels", red_pix, 16);
      checkOutput("post_rst_paused_x", sprite_x, 6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   function automatic int TV_TOTAL_HS();
      return TH_S * V_TOT;
   endfunction

endmodule

// File: doc/vga_sprite_animator.md
Name: vga_sprite_animator

Overview:
- Parametrised VGA timing generator plus moving square-sprite renderer, one pixel per clk.
- Produces standards-correct HS/VS/BLANK with front porch, sync and back porch.
- Moves a square sprite by SPEED pixels per update, at a programmable direction, with bounce or wrap at screen edges.
- Sits between the game-state logic (direction/enable/colour) and the DE-series VGA DAC pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in clk
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- SPRITE_SIZE, 4, sprite edge length in pixels (1..V_ACTIVE)
- SPEED, 2, pixels moved per position update (< SPRITE_SIZE not required)
- FRAME_DIV, 1, position update every FRAME_DIV frames (>=1)
- COLOR_W, 3, bits per colour channel

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- enable  in  1  1 = sprite moves; 0 = sprite frozen, video continues
- bounce_en  in  1  1 = reflect at edges; 0 = wrap to opposite edge
- dir_in  in  2  0 right, 1 down, 2 left, 3 up
- dir_load  in  1  one-cycle strobe capturing dir_in as the pending direction
- sprite_rgb  in  3*COLOR_W  {R,G,B} sprite colour, sampled each pixel
- VGA_R / VGA_G / VGA_B  out  COLOR_W each  pixel colour
- VGA_HS / VGA_VS  out  1  active-low syncs
- VGA_BLANK_N  out  1  high during active video
- VGA_SYNC_N  out  1  constant 0
- frame_start  out  1  one-cycle pulse at h=0, v=V_ACTIVE (start of vertical blank)
- sprite_x  out  clog2(H_ACTIVE)  current sprite left column
- sprite_y  out  clog2(V_ACTIVE)  current sprite top row

Behaviour:
- Counters: h in 0..H_TOTAL-1 (H_TOTAL = sum of H params). v increments when h wraps, range 0..V_TOTAL-1; both wrap to 0.
- Active region: h < H_ACTIVE and v < V_ACTIVE.
- HS low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). VS low for v in the equivalent vertical window.
- All VGA outputs are registered with 1-clk latency from the counters; sync and colour stay aligned.
- Pixel colour:
  - sprite_rgb when active and h in [x, x+SIZE) and v in [y, y+SIZE)
  - 0 elsewhere in the active region
  - 0 in all blanking
- Reset values: h=v=0; HS=VS=1; BLANK_N=0; RGB=0; frame_start=0; x=(H_ACTIVE-SIZE)/2; y=(V_ACTIVE-SIZE)/2; dir=0; pending-dir valid=0; frame divider=0; state PAUSED.
- FSM states: PAUSED, RUN.
  - PAUSED->RUN when enable=1; RUN->PAUSED when enable=0.
  - The transition is evaluated every cycle.
  - Position changes only on frame_start in RUN with divider==FRAME_DIV-1, so there is no tearing.
  - The divider counts frame_starts only in RUN and holds in PAUSED.
- Direction capture: dir_load registers dir_in into pending. The pending direction is applied at the next update, before movement, then cleared. The last strobe wins.
- Update arithmetic: computed at full width + 1 bit, no overflow.
  - Right: nx = x+SPEED. If nx > H_ACTIVE-SIZE:
    - bounce_en=1: x = H_ACTIVE-SIZE and dir becomes left.
    - bounce_en=0: x = 0.
  - Left: if x < SPEED:
    - bounce_en=1: x = 0 and dir becomes right.
    - bounce_en=0: x = H_ACTIVE-SIZE.
  - Down/up: identical rules against V_ACTIVE.
- Simultaneous events:
  - dir_load in the same cycle as an update is not applied until the following update.
  - A bounce reversal overrides the current direction only; a later pending load replaces it.
- reset mid-frame: everything returns to reset values on the next edge. The first frame then starts at h=v=0.

Decomposition:
- Package vga_anim_pkg:
  - direction typedef (DIR_RIGHT/DOWN/LEFT/UP)
  - FSM state typedef
  - default 640x480 timing constants
  - function computing H_TOTAL/V_TOTAL
- Sub-module vga_timing_gen: h/v counters, syncs, active flag, frame_start.
- Sprite FSM, position update and colour mux live in the top level.

Test Plan:
- Timing check: reset 2 clk, run 2 frames -> HS period 800 clk, HS low 96 clk starting h=656; VS low 2 lines starting v=490; BLANK_N high exactly 640x480 per frame; frame_start once per 420000 clk.
- Sprite after reset with enable=0, sprite_rgb=9'h1C0 -> only pixels h 318..321, v 238..241 show R=7; the colour appears 1 clk after the counter; sprite_x=318 stays constant over 3 frames.
- Rightward motion with enable=1, FRAME_DIV=1, SPEED=2 -> sprite_x goes 318,320,322 on successive frame_starts; sprite_y is unchanged.
- Edge behaviour with x forced near the edge via dir/right motion to 634:
  - bounce_en=1: next update x=636 and dir becomes left, then 634.
  - bounce_en=0: x=636 then 0.
- Direction and enable:
  - dir_load with dir_in=3 mid-frame -> next update y decreases by 2.
  - dir_load on the frame_start cycle -> the direction is applied one frame later.
  - enable dropped for 2 frames -> position and divider hold.
- Reset mid-frame at h=300, v=200 -> the next cycle has h=v=0, BLANK_N=0, HS=1, sprite_x=318, and the state is PAUSED.
